scope_capture: RTL and testbench

SCOPE_CAPTURE -- requirements
Module: scope_capture

---
 rtl/scope_capture.sv | 202 ++++++++++++++++++++
 tb/tb_scope_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture.sv
// scope_capture: single-shot oscilloscope capture buffer with pre-trigger history.
//
// After an arm pulse, valid samples are written into a circular buffer. Once
// PRETRIG samples have been collected the block watches for a rising or falling
// crossing of trig_level (signed 8-bit compare against the previous valid
// sample). The trigger sample and the following samples fill the buffer up to
// DEPTH entries, after which the capture is frozen and can be read out with
// rd_addr 0 as the oldest sample and rd_addr PRETRIG as the trigger sample.
//
// Optional feature: define SCOPE_CAPTURE_AUTO_TRIG_EN to force a trigger after
// 4095 valid samples spent waiting for a trigger; trig_auto then flags the capture.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   sample_in     signed 8-bit sample
//   sample_valid  sample_in valid this cycle
//   arm           pulse: start a new capture (sample in the same cycle is dropped)
//   trig_level    signed trigger threshold
//   trig_falling  0 = rising-edge trigger, 1 = falling-edge trigger
//   rd_en         readout request
//   rd_addr       readout index (0 = oldest sample)
//   rd_data       readout sample, registered, 1-cycle latency
//   rd_valid      rd_data valid (only for requests issued while done)
//   busy          capture in progress
//   done          capture complete, buffer readable
//   trig_auto     last capture was forced by the auto-trigger

module scope_capture #(
  parameter int DEPTH   = 256,
  parameter int PRETRIG = 64,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    sample_in,
  input  logic          sample_valid,
  input  logic          arm,
  input  logic [7:0]    trig_level,
  input  logic          trig_falling,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          trig_auto
);

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
  localparam logic [AW:0]   POST_LAST = (AW + 1)'(DEPTH - PRETRIG - 1);
  // With PRETRIG = DEPTH-1 the trigger sample alone completes the capture.
  localparam bit            POST_ONE  = ((DEPTH - PRETRIG) == 1);

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW:0]   post_cnt;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] start_ptr;
  logic [AW-1:0] rd_idx;
  logic [7:0]    prev;
  logic          prev_valid;
  logic          wr_en;
  logic          natural;
  logic          forced;
  logic          hit;
  logic          prev_ge;
  logic          cur_ge;

  assign prev_ge   = $signed(prev) >= $signed(trig_level);
  assign cur_ge    = $signed(sample_in) >= $signed(trig_level);
  assign start_ptr = trig_ptr - PRE_OFS;
  assign rd_idx    = start_ptr + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    natural   = 1'b0;
    hit       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      PREFILL, WAIT_TRIG, POST: busy = 1'b1;
      DONE:                     done = 1'b1;
      default: ;
    endcase
    if (arm) begin
      state_nxt = PREFILL;
    end else begin
      case (state)
        PREFILL: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            if (pre_cnt == PRE_LAST) state_nxt = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (sample_valid) begin
            wr_en   = 1'b1;
            natural = prev_valid &&
                      (trig_falling ? (prev_ge && !cur_ge) : (!prev_ge && cur_ge));
            hit     = natural || forced;
            if (hit) state_nxt = POST_ONE ? DONE : POST;
          end
        end
        POST: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            if (post_cnt == POST_LAST) state_nxt = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_ptr   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (arm) begin
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      prev_valid <= 1'b0;
    end else if (wr_en) begin
      wr_ptr     <= wr_ptr + 1'b1;
      prev       <= sample_in;
      prev_valid <= 1'b1;
      if (state == PREFILL) pre_cnt <= pre_cnt + 1'b1;
      if (hit) begin
        trig_ptr <= wr_ptr;
        post_cnt <= (AW + 1)'(1);
      end else if (state == POST) begin
        post_cnt <= post_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_en && state == DONE) begin
        rd_data  <= mem[rd_idx];
        rd_valid <= 1'b1;
      end
    end
  end

`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
  logic [11:0] wait_cnt;
  logic        trig_auto_q;

  assign forced    = (wait_cnt == '1);
  assign trig_auto = trig_auto_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      trig_auto_q <= 1'b0;
    end else if (arm) begin
      wait_cnt    <= '0;
      trig_auto_q <= 1'b0;
    end else if (wr_en && state == WAIT_TRIG) begin
      if (hit) trig_auto_q <= !natural;
      else     wait_cnt    <= wait_cnt + 1'b1;
    end
  end
`else
  assign forced    = 1'b0;
  assign trig_auto = 1'b0;
`endif

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture (DEPTH=256, PRETRIG=64, default build).
// The reference model keeps the list of valid samples since arm, finds the
// trigger index from the crossing rule, and derives the captured window from it.

module tb_scope_capture;

  localparam int DEPTH   = 256;
  localparam int PRETRIG = 64;
  localparam int AW      = 8;
  localparam int POSTN   = DEPTH - PRETRIG;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic [7:0]    trig_level = '0;
  logic          trig_falling = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          trig_auto;

  always #5 clk = ~clk;

  scope_capture #(.DEPTH(DEPTH), .PRETRIG(PRETRIG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .trig_level(trig_level), .trig_falling(trig_falling),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .trig_auto(trig_auto)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stim[$];
  logic       exp_v = 1'b0;
  logic [7:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: rd_valid must follow a done-state rd_en by exactly one cycle,
  // and each presented rd_data is matched against the scoreboard queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rd_valid || exp_v) begin
      check("rd_valid_latency", {31'd0, rd_valid}, {31'd0, exp_v});
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got data %0h with no expected entry", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", {24'd0, rd_data}, {24'd0, e});
        end
      end
    end
    exp_v = rd_en && done && rst_n;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first index at or after PRETRIG where prev/cur cross the level.
  function automatic int find_trig();
    logic signed [7:0] p, c, l;
    l = trig_level;
    for (int i = PRETRIG; i < stim.size(); i++) begin
      p = stim[i-1];
      c = stim[i];
      if (trig_falling ? (p >= l && c < l) : (p < l && c >= l)) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_valid(input int k, input int gap);
    int idle;
    idle = (gap >= 1) ? gap - 1 : int'($urandom_range(0, 2));
    repeat (idle) begin
      sample_valid = 1'b0;
      sample_in    = 8'($urandom);
      step();
    end
    sample_valid = 1'b1;
    sample_in    = stim[k];
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm          = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 8'h7F;
    step();
    arm          = 1'b0;
    sample_valid = 1'b0;
    check("busy_after_arm", {31'd0, busy}, 32'd1);
    check("done_after_arm", {31'd0, done}, 32'd0);
  endtask

  task automatic capture(input int gap, output int t);
    t = find_trig();
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL model_no_trigger: got -1 expected a trigger index");
      return;
    end
    do_arm();
    for (int k = 0; k < t + POSTN; k++) begin
      if (k == t + POSTN - 1) begin
        check("done_before_last", {31'd0, done}, 32'd0);
        check("busy_before_last", {31'd0, busy}, 32'd1);
      end
      drive_valid(k, gap);
    end
    check("done_after_last", {31'd0, done}, 32'd1);
    check("busy_after_last", {31'd0, busy}, 32'd0);
    check("trig_auto", {31'd0, trig_auto}, 32'd0);
  endtask

  task automatic readout(input int t);
    int off, a;
    off = int'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) begin
      a = (off + i) % DEPTH;
      exp_q.push_back(stim[t - PRETRIG + a]);
      last_rd = stim[t - PRETRIG + a];
      rd_addr = AW'(a);
      rd_en   = 1'b1;
      step();
    end
    rd_en = 1'b0;
    step();
    step();
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic spot(input int a, input logic [7:0] v);
    exp_q.push_back(v);
    last_rd = v;
    rd_addr = AW'(a);
    rd_en   = 1'b1;
    step();
    rd_en = 1'b0;
    step();
    step();
    check("spot_drained", exp_q.size(), 32'd0);
  endtask

  task automatic make_ramp(input int start, input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'(start + i));
  endtask

  task automatic drive_into_post(input int extra);
    int t;
    t = find_trig();
    do_arm();
    for (int k = 0; k < t + extra; k++) drive_valid(k, 1);
  endtask

  initial begin
    int t;
    // Reset state
    repeat (3) step();
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_trig_auto", {31'd0, trig_auto}, 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      sample_valid = 1'b1;
      sample_in    = 8'($urandom);
      step();
    end
    sample_valid = 1'b0;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    step();
    check("idle_rd_data", {24'd0, rd_data}, 32'd0);

    // Ramp, rising trigger at 100
    make_ramp(0, 600);
    trig_level = 8'd100; trig_falling = 1'b0;
    capture(1, t);
    spot(0, 8'd36);
    spot(64, 8'd100);
    spot(255, 8'd35);
    readout(t);

    // rd_en outside DONE: no rd_valid, rd_data holds
    do_arm();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    step();
    check("rd_data_hold", {24'd0, rd_data}, {24'd0, last_rd});

    // Falling trigger at 0 with alternating +5/-5
    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back((i % 2 == 0) ? 8'd5 : 8'hFB);
    trig_level = 8'd0; trig_falling = 1'b1;
    capture(1, t);
    spot(64, 8'hFB);
    readout(t);

    // Crossing during prefill is ignored; the next crossing triggers
    make_ramp(70, 700);
    trig_level = 8'd100; trig_falling = 1'b0;
    capture(1, t);
    spot(64, 8'd100);
    readout(t);

    // 1-in-3 valid ramp gives the same contents
    make_ramp(0, 600);
    capture(3, t);
    spot(0, 8'd36);
    spot(64, 8'd100);
    spot(255, 8'd35);
    readout(t);

    // Re-arm during POST with a valid sample in the arm cycle
    drive_into_post(10);
    capture(1, t);
    readout(t);

    // Reset mid-POST
    drive_into_post(20);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
    check("midrst_trig_auto", {31'd0, trig_auto}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (4) begin
      sample_valid = 1'b1;
      sample_in    = 8'($urandom);
      step();
    end
    sample_valid = 1'b0;
    check("postrst_idle_busy", {31'd0, busy}, 32'd0);

    // Randomized captures with random valid gaps
    for (int r = 0; r < 4; r++) begin
      int tries = 0;
      do begin
        stim.delete();
        for (int i = 0; i < 1200; i++) stim.push_back(8'($urandom));
        trig_level   = 8'($urandom);
        trig_falling = 1'($urandom);
        tries++;
      end while (find_trig() < 0 && tries < 20);
      capture(0, t);
      readout(t);
    end

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
